rlbp_seq_ctrl: RTL and testbench

//  Frame sequencer for the 12-photodiode RLBP analog front end. On start it resets the pixels,

---
 rtl/rlbp_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_rlbp_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rlbp_seq_ctrl.sv
// Frame sequencer for the 12-photodiode RLBP front end: pixel reset, integration,
// sample-hold, then a circular walk of comparator pairs assembled into a pattern word.
module rlbp_seq_ctrl #(
  parameter int N_PD       = 12,
  parameter int INT_W      = 16,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [INT_W-1:0] int_time_i,
  input  logic             cmp_out_i,
  output logic [N_PD-1:0]  pd_a_o,
  output logic [N_PD-1:0]  pd_b_o,
  output logic             sh_rst_o,
  output logic             sw1_o,
  output logic             sw2_o,
  output logic             sh_o,
  output logic             sh_cmp_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [N_PD-1:0]  pattern_o,
  output logic [7:0]       frame_cnt_o
);

  localparam int SW = $clog2(N_PD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_INTEG = 3'd2,
    S_HOLD  = 3'd3,
    S_CMP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_r, state_nxt;
  logic [INT_W-1:0]  cnt_r, cnt_nxt, t_r;
  logic [SW-1:0]     step_r, step_nxt;
  logic              sync1_r, sync2_r;
  logic [N_PD-1:0]   shadow_r, shadow_nxt;
  logic              start_ok, step_last;
  logic [N_PD-1:0]   pd_a_nxt, pd_b_nxt;
  logic              sh_rst_nxt, sw1_nxt, sw2_nxt, sh_nxt, sh_cmp_nxt, busy_nxt, done_nxt;

  function automatic logic [N_PD-1:0] onehot(input logic [SW-1:0] idx);
    logic [N_PD-1:0] r;
    for (int i = 0; i < N_PD; i++) r[i] = (idx == SW'(i));
    return r;
  endfunction

  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] idx);
    return (idx == SW'(N_PD - 1)) ? SW'(0) : idx + SW'(1);
  endfunction

  assign start_ok  = (state_r == S_IDLE) && start_i && !abort_i;
  assign step_last = (cnt_r == INT_W'(SETTLE_CYC + 1));

  // State register, phase counters, latched integration time and synchronizer
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      step_r   <= '0;
      t_r      <= '0;
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      shadow_r <= '0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      step_r   <= step_nxt;
      sync1_r  <= cmp_out_i;
      sync2_r  <= sync1_r;
      shadow_r <= shadow_nxt;
      if (start_ok) t_r <= (int_time_i == '0) ? INT_W'(1) : int_time_i;
      else          t_r <= t_r;
    end
  end

  // Next-state and counter sequencing; abort forces IDLE from any busy state
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    step_nxt   = step_r;
    shadow_nxt = shadow_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_RESET;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RESET: begin
        if (cnt_r == INT_W'(RST_CYC - 1)) begin
          state_nxt = S_INTEG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r + INT_W'(1);
        end
      end
      S_INTEG: begin
        if (cnt_r == t_r - INT_W'(1)) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r + INT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_r == INT_W'(SETTLE_CYC - 1)) begin
          state_nxt = S_CMP;
          cnt_nxt   = '0;
          step_nxt  = '0;
        end else begin
          cnt_nxt = cnt_r + INT_W'(1);
        end
      end
      S_CMP: begin
        if (step_last) begin
          shadow_nxt[step_r] = sync2_r;
          cnt_nxt            = '0;
          if (step_r == SW'(N_PD - 1)) state_nxt = S_DONE;
          else                         step_nxt  = step_r + SW'(1);
        end else begin
          cnt_nxt = cnt_r + INT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        step_nxt  = '0;
      end
    endcase
    if (abort_i && (state_r != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      step_nxt  = '0;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // Output decode from the next state so registered outputs track the state edge
  always_comb begin
    pd_a_nxt   = '0;
    pd_b_nxt   = '0;
    sh_rst_nxt = 1'b0;
    sw1_nxt    = 1'b0;
    sw2_nxt    = 1'b0;
    sh_nxt     = 1'b0;
    sh_cmp_nxt = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = (state_nxt != S_IDLE);
    case (state_nxt)
      S_RESET: begin
        sh_rst_nxt = 1'b1;
        sw1_nxt    = 1'b1;
        pd_a_nxt   = '1;
        pd_b_nxt   = '1;
      end
      S_HOLD:  sh_nxt = 1'b1;
      S_CMP: begin
        sw2_nxt    = 1'b1;
        sh_cmp_nxt = 1'b1;
        pd_a_nxt   = onehot(step_nxt);
        pd_b_nxt   = onehot(next_idx(step_nxt));
      end
      S_DONE:  done_nxt = 1'b1;
      default: done_nxt = 1'b0;
    endcase
  end

  // Output registers; pattern and frame count only move on entry to DONE
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pd_a_o      <= '0;
      pd_b_o      <= '0;
      sh_rst_o    <= 1'b0;
      sw1_o       <= 1'b0;
      sw2_o       <= 1'b0;
      sh_o        <= 1'b0;
      sh_cmp_o    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pattern_o   <= '0;
      frame_cnt_o <= 8'd0;
    end else begin
      pd_a_o   <= pd_a_nxt;
      pd_b_o   <= pd_b_nxt;
      sh_rst_o <= sh_rst_nxt;
      sw1_o    <= sw1_nxt;
      sw2_o    <= sw2_nxt;
      sh_o     <= sh_nxt;
      sh_cmp_o <= sh_cmp_nxt;
      busy_o   <= busy_nxt;
      done_o   <= done_nxt;
      if (done_nxt) begin
        pattern_o   <= shadow_nxt;
        frame_cnt_o <= frame_cnt_o + 8'd1;
      end else begin
        pattern_o   <= pattern_o;
        frame_cnt_o <= frame_cnt_o;
      end
    end
  end

endmodule

// File: tb/tb_rlbp_seq_ctrl.sv
// Scoreboard bench for rlbp_seq_ctrl: expected done cycle, pattern and frame count
// are queued when a frame is started and compared when done_o appears.
module tb_rlbp_seq_ctrl;
  localparam int N  = 12;
  localparam int IW = 16;
  localparam int RC = 4;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, cmp_const, cmp_mode;
  logic [IW-1:0] int_time;
  logic          cmp_drv;
  logic [N-1:0]  pd_a, pd_b, pattern;
  logic          sh_rst, sw1, sw2, sh, sh_cmp, busy, done;
  logic [7:0]    frame_cnt;

  typedef struct {
    int unsigned cyc;
    logic [N-1:0] pat;
    logic [7:0]   fc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          bad_walk = 0;
  logic        wrap_seen = 1'b0;
  logic        done_q = 1'b0;
  int unsigned k;

  rlbp_seq_ctrl #(.N_PD(N), .INT_W(IW), .RST_CYC(RC), .SETTLE_CYC(SC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .int_time_i(int_time), .cmp_out_i(cmp_drv),
    .pd_a_o(pd_a), .pd_b_o(pd_b), .sh_rst_o(sh_rst), .sw1_o(sw1), .sw2_o(sw2),
    .sh_o(sh), .sh_cmp_o(sh_cmp), .busy_o(busy), .done_o(done),
    .pattern_o(pattern), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  // comparator model: constant level, or high while an even photodiode is on the + input
  assign cmp_drv = cmp_mode ? |(pd_a & 12'h555) : cmp_const;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lat(input int unsigned t);
    return RC + ((t == 0) ? 1 : t) + SC + N * (SC + 2);
  endfunction

  // monitor: scoreboard pop on done, walk invariants in CMP
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", {63'd0, done}, 64'd0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", e.cyc == 0 ? 64'd0 : 64'(cyc), 64'(e.cyc));
          chk("pattern", 64'(pattern), 64'(e.pat));
          chk("frame_cnt", 64'(frame_cnt), 64'(e.fc));
        end
      end
      if (done && done_q) bad_walk++;
      done_q = done;
      if (sw2) begin
        if ($countones(pd_a) != 1 || pd_a == pd_b || pd_b != {pd_a[N-2:0], pd_a[N-1]}) bad_walk++;
        if (pd_a == 12'h800 && pd_b == 12'h001) wrap_seen = 1'b1;
      end
    end
  end

  task automatic start_frame(input logic [IW-1:0] t, input logic [N-1:0] pat,
                             input logic [7:0] fc, input logic push, output int unsigned kk);
    @(negedge clk);
    int_time = t;
    start = 1'b1;
    kk = cyc + 1;
    if (push) sb.push_back('{kk + lat(t), pat, fc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] ctl();
    return {58'd0, sh_rst, sw1, sw2, sh, sh_cmp, busy};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmp_const = 1'b0; cmp_mode = 1'b0; int_time = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pd_a, pd_b, sh_rst, sw1, sw2, sh, sh_cmp, busy, done, pattern, frame_cnt}, 64'd0);
    rst = 1'b0;

    // T1: int_time=10, comparator constant high
    cmp_const = 1'b1;
    start_frame(16'd10, 12'hFFF, 8'd1, 1'b1, k);
    wait_cyc(k + 1);
    chk("reset_phase", {ctl(), pd_a, pd_b}, {40'd0, 6'b110001, 12'hFFF, 12'hFFF} >> 0);
    wait_cyc(k + 4);
    chk("integ_phase", {ctl(), pd_a, pd_b}, {40'd0, 6'b000001, 24'd0});
    wait_cyc(k + 14);
    chk("hold_phase", {ctl(), pd_a, pd_b}, {40'd0, 6'b000101, 24'd0});
    wait_cyc(k + 16);
    chk("cmp_step0", {ctl(), pd_a, pd_b}, {40'd0, 6'b001011, 12'h001, 12'h002});
    drain(200);

    // T2: even-indexed comparisons high
    cmp_mode = 1'b1;
    bad_walk = 0;
    wrap_seen = 1'b0;
    start_frame(16'd10, 12'h555, 8'd2, 1'b1, k);
    drain(200);
    chk("walk_errors", 64'(bad_walk), 64'd0);
    chk("wrap_pair_seen", {63'd0, wrap_seen}, 64'd1);

    // T3: int_time=0 behaves as one cycle of integration
    cmp_mode = 1'b0;
    start_frame(16'd0, 12'hFFF, 8'd3, 1'b1, k);
    wait_cyc(k + 4);
    chk("integ_t0", ctl(), 64'b000001);
    wait_cyc(k + 5);
    chk("hold_after_t0", ctl(), 64'b000101);
    drain(200);

    // T4: abort inside CMP, abort beats start in IDLE, then a normal restart
    cmp_mode = 1'b1;
    start_frame(16'd10, 12'h000, 8'd0, 1'b0, k);
    wait_cyc(k + 28);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outputs", {pd_a, pd_b, sh_rst, sw1, sw2, sh, sh_cmp, busy, done}, 64'd0);
    chk("abort_pattern_kept", 64'(pattern), 64'hFFF);
    chk("abort_fcnt_kept", 64'(frame_cnt), 64'd3);
    repeat (80) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start", {63'd0, busy}, 64'd0);
    start_frame(16'd10, 12'h555, 8'd4, 1'b1, k);
    wait_cyc(k + 20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(200);

    // T5: start held high across three frames
    cmp_mode = 1'b0; cmp_const = 1'b0;
    @(negedge clk);
    int_time = 16'd10;
    start = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) sb.push_back('{k + 66 * i + 64, 12'h000, 8'(5 + i)});
    wait_cyc(k + 132);
    start = 1'b0;
    drain(400);

    // T6: 256 back-to-back frames from a fresh reset wrap the frame counter
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("fcnt_after_reset", 64'(frame_cnt), 64'd0);
    cmp_const = 1'b1;
    int_time = 16'd0;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 256; i++) sb.push_back('{k + 57 * i + 55, 12'hFFF, 8'(i + 1)});
    wait_cyc(k + 255 * 57);
    start = 1'b0;
    drain(20000);
    chk("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    // asynchronous reset in the middle of INTEG
    start_frame(16'd100, 12'h000, 8'd0, 1'b0, k);
    wait_cyc(k + 10);
    chk("integ_before_rst", ctl(), 64'b000001);
    #2 rst = 1'b1;
    #1 chk("async_rst_clear", {pd_a, pd_b, sh_rst, sw1, sw2, sh, sh_cmp, busy, done, pattern, frame_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
